// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shifter.
// Build option: SHIFT_ITER_STEP16_EN enables the by-16 step in shift_step/shift_iter.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_1  = 2'd0,
        SEL_4  = 2'd1,
        SEL_16 = 2'd2
    } step_sel_e;

    localparam logic [4:0] STEP_1  = 5'd1;
    localparam logic [4:0] STEP_4  = 5'd4;
    localparam logic [4:0] STEP_16 = 5'd16;

    localparam logic DIR_RIGHT    = 1'b0;
    localparam logic DIR_LEFT     = 1'b1;
    localparam logic MODE_LOGICAL = 1'b0;
    localparam logic MODE_ARITH   = 1'b1;

    function automatic logic [4:0] step_amount(input step_sel_e sel);
        logic [4:0] amt;
        case (sel)
            SEL_1:   amt = STEP_1;
            SEL_4:   amt = STEP_4;
            SEL_16:  amt = STEP_16;
            default: amt = STEP_1;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: by-1, by-4 (and by-16 when SHIFT_ITER_STEP16_EN
// is defined) in left, right-logical and right-arithmetic forms.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] value,
    input  step_sel_e   sel,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] result
);

    logic fill_s;

    assign fill_s = (arith == MODE_ARITH) ? value[31] : 1'b0;

    // Select the shift datapath for the requested step size and direction.
    always_comb begin
        result = value;
        case (sel)
            SEL_1: begin
                if (dir == DIR_LEFT) begin
                    result = {value[30:0], 1'b0};
                end else begin
                    result = {fill_s, value[31:1]};
                end
            end
            SEL_4: begin
                if (dir == DIR_LEFT) begin
                    result = {value[27:0], 4'b0000};
                end else begin
                    result = {{4{fill_s}}, value[31:4]};
                end
            end
`ifdef SHIFT_ITER_STEP16_EN
            SEL_16: begin
                if (dir == DIR_LEFT) begin
                    result = {value[15:0], 16'h0000};
                end else begin
                    result = {{16{fill_s}}, value[31:16]};
                end
            end
`endif
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_iter.sv
// Iterative 32-bit shifter: one step per clock until the latched amount is consumed.
// Build option: SHIFT_ITER_STEP16_EN adds a by-16 step ahead of the by-4 and by-1 steps.
module shift_iter
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        arith,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout
);

    state_e      state_r, state_nx_s;
    logic [31:0] acc_r, acc_nx_s;
    logic [4:0]  rem_r, rem_nx_s;
    logic        dir_r, dir_nx_s;
    logic        arith_r, arith_nx_s;
    logic        busy_r;
    logic        done_r;
    step_sel_e   sel_s;
    logic [31:0] step_out_s;

    // Largest step that still fits in the remaining amount, so rem never underflows.
    always_comb begin
        sel_s = SEL_1;
`ifdef SHIFT_ITER_STEP16_EN
        if (rem_r >= STEP_16) begin
            sel_s = SEL_16;
        end else if (rem_r >= STEP_4) begin
            sel_s = SEL_4;
        end else begin
            sel_s = SEL_1;
        end
`else
        if (rem_r >= STEP_4) begin
            sel_s = SEL_4;
        end else begin
            sel_s = SEL_1;
        end
`endif
    end

    shift_step u_step (
        .value  (acc_r),
        .sel    (sel_s),
        .dir    (dir_r),
        .arith  (arith_r),
        .result (step_out_s)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        rem_nx_s   = rem_r;
        dir_nx_s   = dir_r;
        arith_nx_s = arith_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_nx_s   = din;
                    rem_nx_s   = shamt;
                    dir_nx_s   = dir;
                    arith_nx_s = arith;
                    if (shamt == 5'd0) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_nx_s = step_out_s;
                rem_nx_s = rem_r - step_amount(sel_s);
                if (rem_nx_s == 5'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered status flags; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= 32'h0000_0000;
            rem_r   <= 5'd0;
            dir_r   <= DIR_RIGHT;
            arith_r <= MODE_LOGICAL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            rem_r   <= rem_nx_s;
            dir_r   <= dir_nx_s;
            arith_r <= arith_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dout = acc_r;

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter: directed vector table, hand sequences for the
// ignored-start and mid-shift reset cases, and randomized requests against a model.
module tb_shift_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int total;
    int bad;

    shift_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .dir   (dir),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        dr;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    function automatic int ref_steps(input int s);
`ifdef SHIFT_ITER_STEP16_EN
        return s / 16 + (s % 16) / 4 + s % 4;
`else
        return s / 4 + s % 4;
`endif
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic dr, input logic ar);
        if (dr) return d << s;
        else if (ar) return $unsigned($signed(d) >>> s);
        else return d >> s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one request and observe it until the DUT is back in IDLE.
    // inj > 0 pulses a conflicting start in that cycle after acceptance.
    task automatic run_req(input logic [31:0] d, input logic [4:0] s, input logic dr,
                           input logic ar, input int inj,
                           output logic [31:0] res, output int lat, output int ndone,
                           output int nbusy, output logic [31:0] held);
        din = d; shamt = s; dir = dr; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din = $urandom; shamt = 5'($urandom); dir = 1'($urandom); arith = 1'($urandom);
        lat = -1; ndone = 0; nbusy = 0; res = 32'h0; held = 32'hFFFF_FFFF;
        for (int c = 1; c <= 64; c++) begin
            if (inj != 0 && c == inj) begin
                start = 1'b1; din = 32'hDEAD_BEEF; shamt = 5'd3; dir = ~dr; arith = ~ar;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = dout;
                end
            end
            if (busy) begin
                nbusy++;
            end else begin
                held = dout;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [31:0] d, input logic [4:0] s,
                             input logic dr, input logic ar, input logic [31:0] exp,
                             input int inj);
        logic [31:0] res, held;
        int lat, nd, nb, n;
        n = ref_steps(int'(s));
        run_req(d, s, dr, ar, inj, res, lat, nd, nb, held);
        chk({tag, ".dout"}, res, exp);
        chk({tag, ".latency"}, 32'(lat), 32'(n + 1));
        chk({tag, ".done_count"}, 32'(nd), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(nb), 32'(n + 1));
        chk({tag, ".dout_held"}, held, exp);
    endtask

    vec_t vecs[$];

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; din = 32'h0; shamt = 5'd0; dir = 1'b0; arith = 1'b0;

        vecs.push_back('{32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'hF800_0000});
        vecs.push_back('{32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678});
        vecs.push_back('{32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, 5'd7,  1'b0, 1'b0, 32'h0100_0000});
        vecs.push_back('{32'h8000_0000, 5'd7,  1'b0, 1'b1, 32'hFF00_0000});
        vecs.push_back('{32'hA5A5_A5A5, 5'd5,  1'b1, 1'b0, 32'hB4B4_B4A0});
        vecs.push_back('{32'h7FFF_FFFF, 5'd16, 1'b0, 1'b1, 32'h0000_7FFF});
        vecs.push_back('{32'hFFFF_FFFF, 5'd3,  1'b1, 1'b1, 32'hFFFF_FFF8});
        vecs.push_back('{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF});
        vecs.push_back('{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0001});

        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.dout", dout, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            check_req($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].dr, vecs[i].ar,
                      vecs[i].exp, 0);
        end

        // Conflicting start two cycles into a 9-bit right-logical shift.
        check_req("ignore_start", 32'hF000_000F, 5'd9, 1'b0, 1'b0, 32'h0078_0000, 2);

        // Reset during a 20-bit left shift, then a fresh 1-bit request.
        din = 32'h0000_00FF; shamt = 5'd20; dir = 1'b1; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.dout", dout, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort.no_done", {31'd0, done}, 32'd0);
        end
        check_req("after_abort", 32'h0000_0003, 5'd1, 1'b1, 1'b0, 32'h0000_0006, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic        dr, ar;
            d = $urandom; s = 5'($urandom_range(0, 31)); dr = 1'($urandom); ar = 1'($urandom);
            check_req("rand", d, s, dr, ar, ref_shift(d, s, dr, ar), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
